// File: rtl/prog_loader.sv
// Serial program loader: an 8N1 receiver feeding a frame parser that writes the
// payload into CPU RAM from address 0 and starts the CPU when the checksum matches.

module prog_loader #(
    parameter int         CLKS_PER_BIT = 16,
    parameter logic [7:0] HEADER       = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_data_in,
    output logic       wren,
    output logic       busy,
    output logic       run,
    output logic       done,
    output logic       err,
    output logic [7:0] rx_byte
);

    localparam int            CW      = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_BITS  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_LEN  = 2'd1,
        F_DATA = 2'd2,
        F_SUM  = 2'd3
    } f_state_t;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        logic [8:0] full_s;
        full_s = {1'b0, acc} + {1'b0, b};
        return full_s[7:0];
    endfunction

    logic          rxd_meta_r;
    logic          rxd_sync_r;
    logic          rxd_prev_r;

    rx_state_t     rx_state_r, rx_state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [2:0]    bit_idx_r, bit_idx_s;
    logic [7:0]    shift_r, shift_s;
    logic          byte_valid_r, byte_valid_s;
    logic          frame_err_r, frame_err_s;
    logic [7:0]    rx_byte_s;

    f_state_t      f_state_r, f_state_s;
    logic [7:0]    len_r, len_s;
    logic [7:0]    addr_r, addr_s;
    logic [7:0]    sum_r, sum_s;
    logic [7:0]    ram_addr_s;
    logic [7:0]    ram_data_s;
    logic          wren_s;
    logic          busy_s;
    logic          run_s;
    logic          done_s;
    logic          err_s;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
            rxd_prev_r <= 1'b1;
        end else begin
            rxd_meta_r <= rxd;
            rxd_sync_r <= rxd_meta_r;
            rxd_prev_r <= rxd_sync_r;
        end
    end

    // Byte receiver next-state: mid-bit sampling driven by a single bit-period counter.
    always_comb begin
        rx_state_s   = rx_state_r;
        cnt_s        = cnt_r + CW'(1'b1);
        bit_idx_s    = bit_idx_r;
        shift_s      = shift_r;
        byte_valid_s = 1'b0;
        frame_err_s  = 1'b0;
        rx_byte_s    = rx_byte;
        case (rx_state_r)
            RX_IDLE: begin
                cnt_s = '0;
                if (rxd_prev_r && !rxd_sync_r) begin
                    rx_state_s = RX_START;
                end else begin
                    rx_state_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_r == HALF_M1) begin
                    cnt_s     = '0;
                    bit_idx_s = 3'd0;
                    // A line already back high at mid-start-bit was only a glitch.
                    if (rxd_sync_r) begin
                        rx_state_s = RX_IDLE;
                    end else begin
                        rx_state_s = RX_BITS;
                    end
                end else begin
                    rx_state_s = RX_START;
                end
            end
            RX_BITS: begin
                if (cnt_r == FULL_M1) begin
                    cnt_s     = '0;
                    shift_s   = {rxd_sync_r, shift_r[7:1]};
                    bit_idx_s = bit_idx_r + 3'd1;
                    if (bit_idx_r == 3'd7) begin
                        rx_state_s = RX_STOP;
                    end else begin
                        rx_state_s = RX_BITS;
                    end
                end else begin
                    rx_state_s = RX_BITS;
                end
            end
            RX_STOP: begin
                if (cnt_r == FULL_M1) begin
                    cnt_s      = '0;
                    rx_state_s = RX_IDLE;
                    if (rxd_sync_r) begin
                        byte_valid_s = 1'b1;
                        rx_byte_s    = shift_r;
                    end else begin
                        frame_err_s = 1'b1;
                    end
                end else begin
                    rx_state_s = RX_STOP;
                end
            end
            default: begin
                rx_state_s = RX_IDLE;
                cnt_s      = '0;
            end
        endcase
    end

    // Byte receiver state and strobe registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_r   <= RX_IDLE;
            cnt_r        <= '0;
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'd0;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            rx_byte      <= 8'd0;
        end else begin
            rx_state_r   <= rx_state_s;
            cnt_r        <= cnt_s;
            bit_idx_r    <= bit_idx_s;
            shift_r      <= shift_s;
            byte_valid_r <= byte_valid_s;
            frame_err_r  <= frame_err_s;
            rx_byte      <= rx_byte_s;
        end
    end

    // Frame parser next-state; every output is computed here and registered below.
    always_comb begin
        f_state_s  = f_state_r;
        len_s      = len_r;
        addr_s     = addr_r;
        sum_s      = sum_r;
        ram_addr_s = ram_addr;
        ram_data_s = ram_data_in;
        wren_s     = 1'b0;
        run_s      = 1'b0;
        busy_s     = busy;
        done_s     = done;
        err_s      = err;
        case (f_state_r)
            F_IDLE: begin
                if (byte_valid_r && (rx_byte == HEADER)) begin
                    done_s    = 1'b0;
                    err_s     = 1'b0;
                    busy_s    = 1'b1;
                    f_state_s = F_LEN;
                end else begin
                    f_state_s = F_IDLE;
                end
            end
            F_LEN: begin
                if (frame_err_r) begin
                    err_s     = 1'b1;
                    busy_s    = 1'b0;
                    f_state_s = F_IDLE;
                end else if (byte_valid_r) begin
                    len_s     = rx_byte;
                    addr_s    = 8'd0;
                    sum_s     = 8'd0;
                    f_state_s = F_DATA;
                end else begin
                    f_state_s = F_LEN;
                end
            end
            F_DATA: begin
                if (frame_err_r) begin
                    err_s     = 1'b1;
                    busy_s    = 1'b0;
                    f_state_s = F_IDLE;
                end else if (byte_valid_r) begin
                    ram_addr_s = addr_r;
                    ram_data_s = rx_byte;
                    wren_s     = 1'b1;
                    sum_s      = csum_add(sum_r, rx_byte);
                    addr_s     = addr_r + 8'd1;
                    len_s      = len_r - 8'd1;
                    // A length of 0 wraps through 8'hFF, so 256 bytes end here too.
                    if (len_r == 8'd1) begin
                        f_state_s = F_SUM;
                    end else begin
                        f_state_s = F_DATA;
                    end
                end else begin
                    f_state_s = F_DATA;
                end
            end
            F_SUM: begin
                if (frame_err_r) begin
                    err_s     = 1'b1;
                    busy_s    = 1'b0;
                    f_state_s = F_IDLE;
                end else if (byte_valid_r) begin
                    busy_s    = 1'b0;
                    f_state_s = F_IDLE;
                    if (rx_byte == sum_r) begin
                        done_s = 1'b1;
                        run_s  = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    f_state_s = F_SUM;
                end
            end
            default: begin
                f_state_s = F_IDLE;
                busy_s    = 1'b0;
            end
        endcase
    end

    // Frame parser state, counters and registered RAM/status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_state_r   <= F_IDLE;
            len_r       <= 8'd0;
            addr_r      <= 8'd0;
            sum_r       <= 8'd0;
            ram_addr    <= 8'd0;
            ram_data_in <= 8'd0;
            wren        <= 1'b0;
            busy        <= 1'b0;
            run         <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            f_state_r   <= f_state_s;
            len_r       <= len_s;
            addr_r      <= addr_s;
            sum_r       <= sum_s;
            ram_addr    <= ram_addr_s;
            ram_data_in <= ram_data_s;
            wren        <= wren_s;
            busy        <= busy_s;
            run         <= run_s;
            done        <= done_s;
            err         <= err_s;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: frames are turned into expected RAM writes and
// run pulses up front, and a negedge monitor checks them as the DUT emits them.

module tb_prog_loader;

    localparam int         CPB    = 4;
    localparam logic [7:0] HDR    = 8'hA5;
    localparam int         LAT_NS = 10 * (2 + CPB / 2 + 9 * CPB + 1 + 1);

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] ram_addr;
    logic [7:0] ram_data_in;
    logic       wren;
    logic       busy;
    logic       run;
    logic       done;
    logic       err;
    logic [7:0] rx_byte;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_wr_q[$];
    bit          exp_run_q[$];
    bit          lat_armed = 1'b0;
    time         lat_t = 0;

    prog_loader #(.CLKS_PER_BIT(CPB), .HEADER(HDR)) dut (
        .clk(clk), .rst(rst), .rxd(rxd),
        .ram_addr(ram_addr), .ram_data_in(ram_data_in), .wren(wren),
        .busy(busy), .run(run), .done(done), .err(err), .rx_byte(rx_byte)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write and run pulse the DUT produces must be the next one expected.
    always @(negedge clk) begin
        if (wren) begin
            if (exp_wr_q.size() == 0) begin
                chk("unexpected_wren", {16'd0, ram_addr, ram_data_in}, 32'hFFFF_FFFF);
            end else begin
                chk("wr_addr_data", {16'd0, ram_addr, ram_data_in}, {16'd0, exp_wr_q.pop_front()});
            end
            if (lat_armed && ram_addr == 8'd0) begin
                chk("start_to_wren_ns", 32'($time - lat_t), 32'(LAT_NS));
                lat_armed = 1'b0;
            end
        end
        if (run) begin
            if (exp_run_q.size() == 0) begin
                chk("unexpected_run", 32'd1, 32'd0);
            end else begin
                void'(exp_run_q.pop_front());
                chk("run_busy_done", {30'd0, busy, done}, 32'd1);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_ok;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    function automatic logic [7:0] model_sum(input logic [7:0] pl[$]);
        int s;
        s = 0;
        foreach (pl[i]) s = s + int'(pl[i]);
        return 8'(s % 256);
    endfunction

    // Reference model: a frame yields writes pl[i]@i and a run iff the checksum matches.
    task automatic send_frame(input logic [7:0] pl[$], input logic [7:0] cks, input int gap_max);
        bit good;
        good = (cks == model_sum(pl));
        foreach (pl[i]) exp_wr_q.push_back({8'(i), pl[i]});
        if (good) exp_run_q.push_back(1'b1);
        send_byte(HDR, 1'b1, $urandom_range(0, gap_max));
        send_byte(8'(pl.size()), 1'b1, $urandom_range(0, gap_max));
        foreach (pl[i]) begin
            if (i == 0) begin
                lat_armed = 1'b1;
                lat_t     = $time;
            end
            send_byte(pl[i], 1'b1, $urandom_range(0, gap_max));
        end
        send_byte(cks, 1'b1, 0);
        repeat (3 * CPB + 4) @(negedge clk);
        chk("frame_done_err_busy", {29'd0, done, err, busy}, {29'd0, good, !good, 1'b0});
        chk("frame_rx_byte", {24'd0, rx_byte}, {24'd0, cks});
        chk("frame_wr_drained", exp_wr_q.size(), 32'd0);
        chk("frame_run_drained", exp_run_q.size(), 32'd0);
    endtask

    initial begin
        logic [7:0] pl[$];
        logic [7:0] b;
        logic [7:0] cks;
        logic [7:0] rx_keep;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {7'd0, ram_addr, ram_data_in, wren, busy, run, done, err, rx_byte},
            32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        pl = '{8'h10, 8'h20, 8'h30};
        send_frame(pl, 8'h60, 0);

        pl = '{8'h01, 8'h02};
        send_frame(pl, 8'h04, CPB);

        send_byte(8'h00, 1'b1, CPB);
        send_byte(8'hFF, 1'b1, 0);
        pl = '{8'h7E};
        send_frame(pl, 8'h7E, 0);

        // Framing error on the first data byte.
        send_byte(HDR, 1'b1, 0);
        send_byte(8'h02, 1'b1, 2);
        chk("busy_mid_frame", {31'd0, busy}, 32'd1);
        send_byte(8'h33, 1'b0, 2 * CPB);
        repeat (CPB) @(negedge clk);
        chk("frame_err_flags", {29'd0, done, err, busy}, 32'b010);
        pl = '{8'h5C, 8'hC3};
        send_frame(pl, model_sum(pl), 0);

        for (int n = 0; n < 16; n++) begin
            pl.delete();
            for (int k = 0; k < $urandom_range(1, 8); k++) pl.push_back(8'($urandom_range(0, 255)));
            cks = model_sum(pl);
            if ($urandom_range(0, 2) == 0) cks = cks + 8'($urandom_range(1, 255));
            for (int k = 0; k < $urandom_range(0, 2); k++) begin
                b = 8'($urandom_range(0, 255));
                if (b == HDR) b = 8'h00;
                send_byte(b, 1'b1, $urandom_range(0, CPB));
            end
            send_frame(pl, cks, 2 * CPB);
        end

        pl.delete();
        for (int i = 0; i < 256; i++) pl.push_back(8'(i));
        chk("len0_checksum_model", {24'd0, model_sum(pl)}, 32'h80);
        send_frame(pl, 8'h80, 0);

        // One-cycle low pulse while idle must not produce a byte or an error.
        rx_keep = rx_byte;
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        chk("glitch_flags", {29'd0, done, err, busy}, 32'b100);
        chk("glitch_rx_byte", {24'd0, rx_byte}, {24'd0, rx_keep});

        // Reset after the second data byte of a 5-byte frame.
        exp_wr_q.push_back({8'h00, 8'h11});
        exp_wr_q.push_back({8'h01, 8'h22});
        send_byte(HDR, 1'b1, 0);
        send_byte(8'h05, 1'b1, 0);
        send_byte(8'h11, 1'b1, 0);
        send_byte(8'h22, 1'b1, 0);
        repeat (CPB + 4) @(negedge clk);
        chk("pre_reset_wr_drained", exp_wr_q.size(), 32'd0);
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_reset_outputs", {7'd0, ram_addr, ram_data_in, wren, busy, run, done, err, rx_byte},
            32'd0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (20 * CPB) @(negedge clk);
        chk("post_reset_idle", {29'd0, done, err, busy}, 32'd0);

        pl = '{8'hDE, 8'hAD};
        send_frame(pl, model_sum(pl), CPB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Serial program loader that fills the CPU's 256-byte RAM before execution. It receives a framed 8N1 byte stream and writes the payload into RAM from address 0 upward. It verifies an 8-bit checksum, then pulses `run` to start the CPU. It sits beside `cpu` and drives the RAM write port while `busy` is high. The `cpu` is the RAM reader; this block is its writer.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Must be even and at least 4.
- `HEADER`, default 8'hA5: frame start byte.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low. While `rst`=0 the block is held in reset.
- `rxd`  in  1  serial input. Idles high. Asynchronous to `clk`.
- `ram_addr`  out  8  RAM write address.
- `ram_data_in`  out  8  RAM write data.
- `wren`  out  1  RAM write enable, one-cycle pulse per payload byte.
- `busy`  out  1  high while a frame is in progress. The system uses it to hold the CPU halted and to switch the RAM port to this block.
- `run`  out  1  one-cycle pulse after a good frame. Wired to `cpu.run`.
- `done`  out  1  sticky; set by a good frame.
- `err`  out  1  sticky; set by a checksum or framing error.
- `rx_byte`  out  8  last byte received, for debug.

## Operation
- **Synchronizer:** `rxd` passes through two flops before any use. This adds 2 cycles of latency.
- **Byte receiver FSM:**
  - RX_IDLE: wait for a high-to-low transition on the synchronized line.
  - RX_START: wait `CLKS_PER_BIT/2` cycles, then re-sample. If the line is high, treat it as a glitch and return to RX_IDLE with no error. Otherwise go to RX_BITS.
  - RX_BITS: sample 8 data bits, LSB first, each `CLKS_PER_BIT` cycles after the previous sample.
  - RX_STOP: sample the stop bit after `CLKS_PER_BIT` cycles. If it is 1, raise internal `byte_valid` for one cycle. If it is 0, raise `frame_err` for one cycle. Either way, return to RX_IDLE.
- **Frame FSM:**
  - F_IDLE:
    - A valid byte equal to `HEADER` clears `done` and `err`, sets `busy`, and moves to F_LEN.
    - Any other byte is ignored.
  - F_LEN:
    - The valid byte is loaded into the length counter `len`. The value 0 means 256 bytes.
    - `addr` is cleared to 0 and `sum` is cleared to 0.
    - Next state is F_DATA.
  - F_DATA, on each valid byte:
    - `ram_addr` = `addr`, `ram_data_in` = byte, and `wren` pulses.
    - `sum` = (`sum` + byte) mod 256.
    - `addr` increments and `len` decrements.
    - After the last byte, move to F_SUM.
    - `addr` wraps from 8'hFF to 0 only after a 256-byte payload, at which point the frame has already ended.
  - F_SUM:
    - If the byte equals `sum`: set `done`, pulse `run`, clear `busy`, and go to F_IDLE.
    - Otherwise: set `err`, clear `busy`, go to F_IDLE, and do not pulse `run`.
- **Framing errors:** a `frame_err` in F_LEN, F_DATA or F_SUM sets `err`, clears `busy` and returns to F_IDLE. RAM bytes already written stay written. A `frame_err` in F_IDLE is ignored.
- **No timeout:** a stalled line holds `busy` indefinitely. Recovery is by reset only.
- **Reset mid-frame:** all state clears immediately and no further writes occur. Partial RAM contents remain.
- **Reset values:** `ram_addr`=0, `ram_data_in`=0, `wren`=0, `busy`=0, `run`=0, `done`=0, `err`=0, `rx_byte`=0, both FSMs idle, synchronizer flops=1.

## Timing
- All outputs are registered.
- `wren`, `ram_addr` and `ram_data_in` are valid in the same cycle, exactly one cycle after the stop-bit sample cycle.
- `run` asserts one cycle after the checksum's stop-bit sample. `busy` falls and `done` rises in that same cycle.
- Start bit to `wren`: 2 (synchronizer) + `CLKS_PER_BIT`/2 + 9×`CLKS_PER_BIT` + 1 cycles.
- Back-to-back bytes with no idle time between stop and next start are accepted with no loss.
- `busy` rises one cycle after the header's stop-bit sample.

## Test plan
- **Good 3-byte load:** `CLKS_PER_BIT`=4; send A5, 03, 10, 20, 30, 60. Expect `wren` pulses at addresses 0, 1, 2 with data 10, 20, 30; one `run` pulse; `done`=1, `err`=0, `busy`=0.
- **Bad checksum:** send A5, 02, 01, 02, 04. Expect two writes, no `run`, `err`=1, `done`=0.
- **Noise before header:** send 00, FF, then a good frame A5, 01, 7E, 7E. Expect the non-header bytes ignored; one write of 7E at address 0; `run` pulse.
- **Framing error:** send A5, 02, then a data byte with stop bit 0. Expect `err`=1, `busy`=0, no further writes. A following good frame clears `err` and pulses `run`.
- **Length 0 (256 bytes):** payload i = address i, 256 bytes; checksum 80. Expect 256 writes at addresses 0..FF, then a `run` pulse.
- **Reset mid-payload:** drop `rst` to 0 after the second data byte. Expect all outputs at reset values immediately and no `wren` after reset.
- **Glitch:** a 1-cycle low pulse on `rxd` in idle produces no byte and no error.
